// File: rtl/alu_pkg.sv
// alu_pkg: operand select encodings and default datapath width shared by the ALU operand stage
package alu_pkg;
  localparam int XLEN_DEF = 32;
  localparam logic [1:0] ASEL_ZERO = 2'b00;
  localparam logic [1:0] ASEL_RSVD = 2'b01;
  localparam logic [1:0] ASEL_PC = 2'b10;
  localparam logic [1:0] ASEL_RS1 = 2'b11;
  localparam logic [1:0] BSEL_SHAMT = 2'b00;
  localparam logic [1:0] BSEL_RS2 = 2'b01;
  localparam logic [1:0] BSEL_IMM = 2'b10;
  localparam logic [1:0] BSEL_FOUR = 2'b11;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority forwarding match for one source operand, lowest index wins, x0 reads zero
module fwd_select #(
  parameter int XLEN = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              addr,
  input  logic [XLEN-1:0]         rval,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_busy,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  output logic [XLEN-1:0]         val,
  output logic                    busy
);
  always_comb begin
    val = rval;
    busy = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (fwd_valid[i] && fwd_rd[5*i +: 5] == addr) begin
        val = fwd_busy[i] ? rval : fwd_data[XLEN*i +: XLEN];
        busy = fwd_busy[i];
      end
    val = addr == 5'd0 ? '0 : val;
    busy = addr != 5'd0 && busy;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: registered ALU operand select with forwarding, load-use stall, handshake, flush and stall counter
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int SHAMT_W = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              ASel,
  input  logic [1:0]              BSel,
  input  logic                    rs2_store,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rs1,
  input  logic [XLEN-1:0]         rs2,
  input  logic [XLEN-1:0]         imm,
  input  logic [XLEN-1:0]         pc,
  input  logic [SHAMT_W-1:0]      shamt,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_busy,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out1,
  output logic [XLEN-1:0]         out2,
  output logic [XLEN-1:0]         store_data,
  output logic [CNT_W-1:0]        stall_cnt
);
  logic [XLEN-1:0] v1, v2, a_nxt, b_nxt;
  logic busy1, busy2, hazard, cap;
  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .addr(rs1_addr), .rval(rs1), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .val(v1), .busy(busy1)
  );
  fwd_select #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .addr(rs2_addr), .rval(rs2), .fwd_valid(fwd_valid), .fwd_busy(fwd_busy),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .val(v2), .busy(busy2)
  );
  always_comb begin
    hazard = in_valid && ((ASel == ASEL_RS1 && busy1) || ((BSel == BSEL_RS2 || rs2_store) && busy2));
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    cap = in_valid && in_ready;
    a_nxt = ASel == ASEL_ZERO ? '0 : ASel == ASEL_RS1 ? v1 : pc;
    b_nxt = ASel == ASEL_RSVD ? imm :
            BSel == BSEL_SHAMT ? {{(XLEN-SHAMT_W){1'b0}}, shamt} :
            BSel == BSEL_RS2 ? v2 :
            BSel == BSEL_IMM ? imm : XLEN'(4);
  end
  always_ff @(posedge clk)
    if (reset) begin
      out_valid <= 1'b0;
      out1 <= '0;
      out2 <= '0;
      store_data <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (cap) begin
        out_valid <= 1'b1;
        out1 <= a_nxt;
        out2 <= b_nxt;
        store_data <= v2;
      end else if (out_ready)
        out_valid <= 1'b0;
      if (hazard && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: table-driven and scoreboarded check of the ALU operand stage
module tb_alu_operand_stage;
  localparam int CW = 4;
  logic clk, reset, in_valid, in_ready, rs2_store, flush, out_valid, out_ready;
  logic [1:0] ASel, BSel;
  logic [4:0] rs1_addr, rs2_addr, shamt;
  logic [31:0] rs1, rs2, imm, pc, out1, out2, store_data;
  logic [2:0] fwd_valid, fwd_busy;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic [CW-1:0] stall_cnt;
  typedef struct {
    logic [1:0] asel, bsel;
    logic st;
    logic [4:0] a1, a2;
    logic [31:0] r1, r2, imm, pc;
    logic [4:0] sh;
    logic [2:0] fv, fb;
    logic [14:0] rd;
    logic [95:0] fd;
    logic [31:0] e1, e2, esd;
  } vec_t;
  typedef struct {
    logic [31:0] e1, e2, esd;
  } exp_t;
  vec_t v[12];
  vec_t x;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [CW-1:0] exp_stall = '0;
  alu_operand_stage #(.XLEN(32), .SHAMT_W(5), .NUM_FWD(3), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ASel(ASel), .BSel(BSel), .rs2_store(rs2_store), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .imm(imm), .pc(pc), .shamt(shamt),
    .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .store_data(store_data), .stall_cnt(stall_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    ASel = t.asel; BSel = t.bsel; rs2_store = t.st; rs1_addr = t.a1; rs2_addr = t.a2;
    rs1 = t.r1; rs2 = t.r2; imm = t.imm; pc = t.pc; shamt = t.sh;
    fwd_valid = t.fv; fwd_busy = t.fb; fwd_rd = t.rd; fwd_data = t.fd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] esd);
    exp_t e;
    e.e1 = e1; e.e2 = e2; e.esd = esd;
    sb.push_back(e);
  endtask
  task automatic stall_step();
    exp_stall = exp_stall == '1 ? exp_stall : exp_stall + 1'b1;
  endtask
  always @(negedge clk)
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output out1 %0h out2 %0h", out1, out2);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out1", {32'd0, out1}, {32'd0, e.e1});
        chk("out2", {32'd0, out2}, {32'd0, e.e2});
        chk("store_data", {32'd0, store_data}, {32'd0, e.esd});
      end
    end
  initial begin
    v[0]  = '{2'b11, 2'b10, 1'b0, 5'd1, 5'd2, 32'h10, 32'h22, 32'h5, 32'h0, 5'd0, 3'b000, 3'b000, 15'd0, 96'd0, 32'h10, 32'h5, 32'h22};
    v[1]  = '{2'b00, 2'b00, 1'b0, 5'd1, 5'd2, 32'h10, 32'h22, 32'h5, 32'h0, 5'h1F, 3'b000, 3'b000, 15'd0, 96'd0, 32'h0, 32'h1F, 32'h22};
    v[2]  = '{2'b11, 2'b10, 1'b0, 5'd3, 5'd2, 32'h55, 32'h22, 32'h5, 32'h0, 5'd0, 3'b111, 3'b000, {5'd3, 5'd3, 5'd3}, {32'hCC, 32'hBB, 32'hAA}, 32'hAA, 32'h5, 32'h22};
    v[3]  = '{2'b11, 2'b10, 1'b0, 5'd0, 5'd2, 32'h55, 32'h22, 32'h5, 32'h0, 5'd0, 3'b111, 3'b000, {5'd0, 5'd0, 5'd0}, {32'hCC, 32'hBB, 32'hAA}, 32'h0, 32'h5, 32'h22};
    v[4]  = '{2'b11, 2'b10, 1'b0, 5'd3, 5'd2, 32'h55, 32'h22, 32'h5, 32'h0, 5'd0, 3'b110, 3'b000, {5'd3, 5'd3, 5'd3}, {32'hCC, 32'hBB, 32'hAA}, 32'hBB, 32'h5, 32'h22};
    v[5]  = '{2'b11, 2'b10, 1'b0, 5'd3, 5'd2, 32'h55, 32'h22, 32'h5, 32'h0, 5'd0, 3'b111, 3'b000, {5'd3, 5'd4, 5'd4}, {32'hCC, 32'hBB, 32'hAA}, 32'hCC, 32'h5, 32'h22};
    v[6]  = '{2'b10, 2'b11, 1'b0, 5'd1, 5'd2, 32'h55, 32'h22, 32'h5, 32'h100, 5'd0, 3'b000, 3'b000, 15'd0, 96'd0, 32'h100, 32'h4, 32'h22};
    v[7]  = '{2'b01, 2'b00, 1'b0, 5'd1, 5'd2, 32'h55, 32'h22, 32'h33, 32'h200, 5'd7, 3'b000, 3'b000, 15'd0, 96'd0, 32'h200, 32'h33, 32'h22};
    v[8]  = '{2'b00, 2'b10, 1'b1, 5'd1, 5'd7, 32'h55, 32'h22, 32'h8, 32'h0, 5'd0, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, {64'd0, 32'h77}, 32'h0, 32'h8, 32'h77};
    v[9]  = '{2'b00, 2'b10, 1'b0, 5'd5, 5'd6, 32'h55, 32'h66, 32'h9, 32'h0, 5'd0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd5}, {64'd0, 32'hDEAD}, 32'h0, 32'h9, 32'h66};
    v[10] = '{2'b11, 2'b01, 1'b0, 5'd0, 5'd9, 32'hFFFF, 32'h22, 32'h5, 32'h0, 5'd0, 3'b010, 3'b000, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h1234, 32'd0}, 32'h0, 32'h1234, 32'h1234};
    v[11] = '{2'b11, 2'b11, 1'b0, 5'd0, 5'd2, 32'hFFFF, 32'h22, 32'h5, 32'h0, 5'd0, 3'b001, 3'b001, 15'd0, {64'd0, 32'hBAD}, 32'h0, 32'h4, 32'h22};
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(v[0]);
    tick();
    tick();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out1", {32'd0, out1}, 64'd0);
    chk("rst_out2", {32'd0, out2}, 64'd0);
    chk("rst_store_data", {32'd0, store_data}, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(v[i]);
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
      if (in_ready) push(v[i].e1, v[i].e2, v[i].esd);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    x = '{2'b00, 2'b01, 1'b0, 5'd1, 5'd7, 32'h55, 32'h1, 32'h5, 32'h0, 5'd0, 3'b001, 3'b001, {5'd0, 5'd0, 5'd7}, 96'd0, 32'h0, 32'h0, 32'h0};
    drive(x);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("loaduse_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      stall_step();
    end
    chk("loaduse_stall_cnt", {60'd0, stall_cnt}, {60'd0, exp_stall});
    fwd_busy = 3'b000;
    fwd_data = {64'd0, 32'h99};
    @(negedge clk);
    chk("loaduse_release_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) push(32'h0, 32'h99, 32'h99);
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    x = '{2'b10, 2'b10, 1'b0, 5'd1, 5'd2, 32'h55, 32'h22, 32'h44, 32'h300, 5'd0, 3'b000, 3'b000, 15'd0, 96'd0, 32'h0, 32'h0, 32'h0};
    drive(x);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_first_ready", {63'd0, in_ready}, 64'd1);
    tick();
    pc = 32'h400; imm = 32'h55;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_out1", {32'd0, out1}, 64'h300);
      chk("bp_out2", {32'd0, out2}, 64'h44);
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    ASel = 2'b11; rs1_addr = 5'd1;
    fwd_valid = 3'b001; fwd_busy = 3'b001; fwd_rd = {5'd0, 5'd0, 5'd1}; fwd_data = {64'd0, 32'h5A};
    tick();
    chk("flush_hazard_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_hazard_stall_cnt", {60'd0, stall_cnt}, {60'd0, exp_stall});
    flush = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      stall_step();
    end
    chk("sat_stall_cnt", {60'd0, stall_cnt}, {60'd0, exp_stall});
    chk("sat_all_ones", {60'd0, stall_cnt}, 64'hF);
    fwd_busy = 3'b000;
    @(negedge clk);
    chk("sat_release_ready", {63'd0, in_ready}, 64'd1);
    if (in_ready) push(32'h5A, 32'h55, 32'h22);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("final_stall_cnt", {60'd0, stall_cnt}, 64'hF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered operand-select stage between decode and the ALU.
- Selects ALU operand A and operand B from pc, rs1, rs2, imm, shamt and constants, with the same ASel/BSel encodings as the existing operand mux.
- Adds a parametrised N-source forwarding network, load-use hazard stalling, a valid/ready handshake on both sides, flush, and a saturating stall-cycle counter.

Parameters:
XLEN, 32, datapath width in bits
SHAMT_W, 5, shift-amount width; zero-extended to XLEN
NUM_FWD, 3, number of forwarding sources; index 0 is the youngest and has the highest priority
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts this cycle
ASel  in  2  operand A select: 00=zero, 10=pc, 11=rs1, 01=reserved
BSel  in  2  operand B select: 00=shamt, 01=rs2, 10=imm, 11=constant 4
rs2_store  in  1  rs2 is consumed as store data
rs1_addr, rs2_addr  in  5 each  source register indices
rs1, rs2, imm, pc  in  XLEN each  register-file and decode values
shamt  in  SHAMT_W  shift amount
fwd_valid  in  NUM_FWD  source i holds a register write
fwd_busy  in  NUM_FWD  source i's data is not yet available (load in flight)
fwd_rd  in  5*NUM_FWD  destination register of source i, packed
fwd_data  in  XLEN*NUM_FWD  result of source i, packed
flush  in  1  kill held and incoming instruction
out_valid  out  1  operands valid
out_ready  in  1  ALU consumes
out1, out2  out  XLEN each  operand A and operand B
store_data  out  XLEN  forwarded rs2
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (synchronous, active-high; sampled on clk rising edge):
  - out_valid=0, out1=0, out2=0, store_data=0, stall_cnt=0.
  - Reset during a held instruction discards it.
- Forwarding, per source operand:
  - A source matches when fwd_valid[i]=1, fwd_rd[i]=addr and addr≠0.
  - The lowest matching index wins.
  - If the winner has fwd_busy=0: the value is fwd_data[i]. Otherwise the value is the register-file value.
  - x0 always reads 0, regardless of fwd inputs or rs value.
- Use rules:
  - rs1 is used iff ASel=11.
  - rs2 is used iff BSel=01 or rs2_store=1.
- Hazard:
  - hazard = in_valid and a used operand's winning match has fwd_busy=1.
  - A busy match on an unused operand is ignored.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard && !flush.
  - Capture occurs on in_valid && in_ready.
  - Held outputs stay stable while out_valid && !out_ready.
- Output register update, in priority order:
  1. reset
  2. flush: out_valid←0; nothing captured
  3. capture: operands latched, out_valid←1
  4. out_ready && out_valid: out_valid←0
  5. otherwise hold
- Operand A on capture: 00→0; 10→pc; 11→fwd(rs1).
- Operand B on capture: 00→{0, shamt}; 01→fwd(rs2); 10→imm; 11→XLEN'd4.
- Reserved ASel=01: out1=pc and out2=imm, irrespective of BSel.
- store_data ← fwd(rs2) on every capture.
- Latency: 1 cycle from capture to out_valid. Full throughput, one per cycle, when out_ready is held at 1.
- stall_cnt: +1 on each cycle with hazard && !flush; saturates at all-ones and never wraps.
- Simultaneous flush and hazard: flush wins; the counter does not increment.
- Back-to-back captures while out_ready=1: new operands replace old in the same cycle, with no bubble.

Decomposition:
- Shared package (alu_pkg):
  - ASel constants: ASEL_ZERO=00, ASEL_PC=10, ASEL_RS1=11.
  - BSel constants: BSEL_SHAMT=00, BSEL_RS2=01, BSEL_IMM=10, BSEL_FOUR=11.
  - XLEN default.
- One sub-module, fwd_select:
  - Parametrised priority match for a single operand: addr, reg value, fwd bundle in; value and busy flag out.
  - Instantiated twice, once for rs1 and once for rs2.

Test Plan:
1. Reset: assert reset for 2 cycles with in_valid=1 → out_valid=0, out1=out2=store_data=0, stall_cnt=0.
2. Plain select: ASel=11, BSel=10, rs1=0x10, imm=0x5, no fwd_valid → next cycle out_valid=1, out1=0x10, out2=0x5. Then ASel=00, BSel=00, shamt=0x1F → out1=0, out2=0x1F.
3. Forward priority: rs1_addr=3, fwd_rd={3,3,3}, fwd_data={0xAA,0xBB,0xCC}, fwd_valid=111, busy=000 → out1=0xAA (index 0). With rs1_addr=0 → out1=0.
4. Load-use: BSel=01, rs2_addr=7, fwd0 rd=7, busy=1 for 3 cycles → in_ready=0 for 3 cycles, stall_cnt=3. When busy drops with data 0x99 → out2=0x99.
5. Backpressure and flush:
   - out_ready=0 with a held instruction → outputs stable and in_ready=0.
   - Assert flush → next cycle out_valid=0 and no capture that cycle.
6. Link and reserved: ASel=10, BSel=11, pc=0x100 → out1=0x100, out2=4. ASel=01 → out1=pc, out2=imm. rs2_store=1, BSel=10, rs2 forwarded 0x77 → store_data=0x77, out2=imm.
